// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - state encoding and frame geometry shared by the conv result sequencer
package conv_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_POOL,
    S_READ,
    S_WAIT_ACK,
    S_DONE
  } seq_state_t;

  localparam int IMG_W_DEF  = 28;
  localparam int ADDR_W_DEF = 10;
  localparam int POOL_W     = IMG_W_DEF / 2;
  localparam int POOL_PIX   = POOL_W * POOL_W;
  localparam int CH_PIX     = IMG_W_DEF * IMG_W_DEF;

endpackage

// File: rtl/pool_walk_gen.sv
// rtl/pool_walk_gen.sv - 2x2/stride-2 window walker (r outer, c fastest) giving base address and pooled index
module pool_walk_gen
  import conv_seq_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic              last,
  output logic [ADDR_W-1:0] base,
  output logic [7:0]        index
);

  localparam int PW = IMG_W / 2;

  logic [4:0] r;
  logic [4:0] c;

  assign last  = (r == 5'(PW - 1)) && (c == 5'(PW - 1));
  assign base  = ADDR_W'(32'(r) * (2 * IMG_W) + 32'(c) * 2);
  assign index = 8'(32'(r) * PW + 32'(c));

  // The walk wraps to (0,0) after the last window so the next phase starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      c <= '0;
    end else if (clear) begin
      r <= '0;
      c <= '0;
    end else if (advance) begin
      if (c == 5'(PW - 1)) begin
        c <= '0;
        r <= last ? '0 : r + 5'd1;
      end else begin
        c <= c + 5'd1;
      end
    end
  end

endmodule

// File: rtl/conv_result_sequencer.sv
// rtl/conv_result_sequencer.sv - accumulate/pool/readout sequencer for the conv result register file
// Optional busy-cycle counter enabled by SEQ_PERF_CNT_EN.
module conv_result_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int OUT_CH = 8,
  parameter int IN_CH  = 4,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_value,
  input  logic [7:0]        in_bias,
  output logic              rf_store,
  output logic              rf_pool,
  output logic              rf_addr_gen,
  output logic [3:0]        rf_out_c,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_first_write,
  output logic [7:0]        rf_value,
  output logic [7:0]        rf_bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_index,
  output logic              busy,
  output logic              done,
  output logic [31:0]       perf_cycles
);

  localparam int NPIX = IMG_W * IMG_W;

  seq_state_t        state;
  seq_state_t        state_nx;
  logic [ADDR_W-1:0] pix;
  logic [3:0]        oc;
  logic [7:0]        ic;
  logic [ADDR_W-1:0] addr_q;
  logic              pool_drain;
  logic              beat;
  logic              last_beat;
  logic              kick;
  logic              xfer;
  logic              pw_adv;
  logic              pw_clr;
  logic              pw_last;
  logic [ADDR_W-1:0] pw_base;
  logic [7:0]        pw_index;

  assign in_ready    = (state == S_ACCUM);
  assign beat        = in_valid && in_ready && !abort;
  assign last_beat   = beat && (pix == ADDR_W'(NPIX - 1)) && (oc == 4'(OUT_CH - 1)) &&
                       (ic == 8'(IN_CH - 1));
  assign kick        = start && !abort && ((state == S_IDLE) || (state == S_DONE));
  assign out_valid   = (state == S_WAIT_ACK) && !abort;
  assign xfer        = out_valid && out_ready;
  assign rf_addr_gen = (state == S_READ) && !abort;
  assign rf_addr     = (state == S_READ) ? pw_base : addr_q;
  assign out_index   = (state == S_WAIT_ACK) ? pw_index : 8'd0;
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);

  pool_walk_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_walk (
    .clk    (clk),
    .rst    (rst),
    .clear  (pw_clr),
    .advance(pw_adv),
    .last   (pw_last),
    .base   (pw_base),
    .index  (pw_index)
  );

  // POOL spends one extra drain cycle so the registered rf_pool never overlaps READ's rf_addr_gen.
  always_comb begin
    state_nx = state;
    pw_adv   = 1'b0;
    pw_clr   = 1'b0;
    if (abort) begin
      state_nx = S_IDLE;
      pw_clr   = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_nx = S_ACCUM;
            pw_clr   = 1'b1;
          end
        end
        S_ACCUM:    if (last_beat) state_nx = S_POOL;
        S_POOL: begin
          if (pool_drain) state_nx = S_READ;
          else            pw_adv   = 1'b1;
        end
        S_READ:     state_nx = S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (xfer) begin
            pw_adv   = 1'b1;
            state_nx = pw_last ? S_DONE : S_READ;
          end
        end
        default:    state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      pix            <= '0;
      oc             <= '0;
      ic             <= '0;
      addr_q         <= '0;
      pool_drain     <= 1'b0;
      rf_store       <= 1'b0;
      rf_pool        <= 1'b0;
      rf_out_c       <= '0;
      rf_first_write <= 1'b0;
      rf_value       <= '0;
      rf_bias        <= '0;
    end else begin
      state      <= state_nx;
      rf_store   <= beat;
      rf_pool    <= (state == S_POOL) && !pool_drain && !abort;
      pool_drain <= (state == S_POOL) && !pool_drain && pw_last && !abort;
      if (kick) begin
        pix <= '0;
        oc  <= '0;
        ic  <= '0;
      end else if (beat) begin
        rf_out_c       <= oc;
        addr_q         <= pix;
        rf_first_write <= (ic == 8'd0);
        rf_value       <= in_value;
        rf_bias        <= in_bias;
        if (pix == ADDR_W'(NPIX - 1)) begin
          pix <= '0;
          if (oc == 4'(OUT_CH - 1)) begin
            oc <= '0;
            ic <= (ic == 8'(IN_CH - 1)) ? 8'd0 : ic + 8'd1;
          end else begin
            oc <= oc + 4'd1;
          end
        end else begin
          pix <= pix + ADDR_W'(1);
        end
      end
      if ((state == S_POOL) && !pool_drain) addr_q <= pw_base;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          perf_q <= '0;
    else if (kick)                    perf_q <= '0;
    else if (busy && (perf_q != '1))  perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_conv_result_sequencer.sv
// tb/tb_conv_result_sequencer.sv - scoreboard bench for conv_result_sequencer (IN_CH=2)
module tb_conv_result_sequencer;

  localparam int NPIX  = 784;
  localparam int TOTAL = 2 * 8 * NPIX;

  typedef struct packed {
    logic [3:0] oc;
    logic [9:0] addr;
    logic       fw;
    logic [7:0] v;
    logic [7:0] b;
  } st_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_value = '0;
  logic [7:0]  in_bias = '0;
  logic        rf_store;
  logic        rf_pool;
  logic        rf_addr_gen;
  logic [3:0]  rf_out_c;
  logic [9:0]  rf_addr;
  logic        rf_first_write;
  logic [7:0]  rf_value;
  logic [7:0]  rf_bias;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_index;
  logic        busy;
  logic        done;
  logic [31:0] perf_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_result_sequencer #(.IMG_W(28), .OUT_CH(8), .IN_CH(2), .ADDR_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_value      (in_value),
    .in_bias       (in_bias),
    .rf_store      (rf_store),
    .rf_pool       (rf_pool),
    .rf_addr_gen   (rf_addr_gen),
    .rf_out_c      (rf_out_c),
    .rf_addr       (rf_addr),
    .rf_first_write(rf_first_write),
    .rf_value      (rf_value),
    .rf_bias       (rf_bias),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .busy          (busy),
    .done          (done),
    .perf_cycles   (perf_cycles)
  );

  function automatic logic [9:0] base_of(input int k);
    return 10'(56 * (k / 14) + 2 * (k % 14));
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({rf_store, rf_pool, rf_addr_gen, rf_out_c, rf_addr, rf_first_write, rf_value, rf_bias,
         out_valid, out_index, busy, done, perf_cycles} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b done=%b rf_addr=%0d want all zero", busy, done, rf_addr);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_accum();
    do_start();
    in_valid = 1'b1;
    repeat (100) begin
      in_value = 8'($urandom);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rf_store, rf_pool, rf_addr_gen, rf_out_c, rf_addr, rf_first_write, rf_value, rf_bias,
         out_valid, out_index, busy, done, in_ready, perf_cycles} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs got busy=%b in_ready=%b rf_addr=%0d want all zero", busy, in_ready, rf_addr);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_start();
    in_valid = 1'b1;
    in_value = 8'h5a;
    in_bias  = 8'hc3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({rf_store, rf_out_c, rf_addr, rf_first_write, rf_value, rf_bias} !== {1'b1, 4'd0, 10'd0, 1'b1, 8'h5a, 8'hc3}) begin
      n_bad++;
      $display("FAIL restart_beat got store=%b oc=%0d addr=%0d fw=%b want store=1 oc=0 addr=0 fw=1",
               rf_store, rf_out_c, rf_addr, rf_first_write);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_accum busy got=%b want=0", busy);
    end
  endtask

  task automatic test_accum_stream(input bit toggle);
    st_t q[$];
    st_t e;
    st_t got;
    int  n = 0;
    int  pulses = 0;
    int  fw_cnt = 0;
    int  cyc = 0;
    int  excl_bad = 0;
    bit  acc;
    do_start();
    n_cmp++;
    if (perf_cycles !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_restart got=%0d want=0", perf_cycles);
    end
    while ((n < TOTAL || q.size() != 0) && cyc < 60000) begin
      in_valid = (n < TOTAL) && (!toggle || cyc[0] == 1'b0);
      in_value = 8'($urandom);
      in_bias  = 8'($urandom);
      acc = in_valid && in_ready;
      if (acc) begin
        e.oc   = 4'((n / NPIX) % 8);
        e.addr = 10'(n % NPIX);
        e.fw   = (n < 8 * NPIX);
        e.v    = in_value;
        e.b    = in_bias;
        q.push_back(e);
        n++;
      end
      @(posedge clk); #1;
      cyc++;
      in_valid = 1'b0;
      if (int'(rf_store) + int'(rf_pool) + int'(rf_addr_gen) > 1) excl_bad++;
      n_cmp++;
      if (rf_store !== acc) begin
        n_bad++;
        $display("FAIL store_strobe cycle %0d got=%b want=%b", cyc, rf_store, acc);
      end
      if (rf_store && q.size() != 0) begin
        pulses++;
        got = {rf_out_c, rf_addr, rf_first_write, rf_value, rf_bias};
        e = q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL store_fields pulse %0d got=%h want=%h", pulses, got, e);
        end
        if (rf_first_write) fw_cnt++;
        if (pulses == 785) begin
          n_cmp++;
          if ({rf_out_c, rf_addr} !== {4'd1, 10'd0}) begin
            n_bad++;
            $display("FAIL pulse785 got oc=%0d addr=%0d want oc=1 addr=0", rf_out_c, rf_addr);
          end
        end
      end
    end
    n_cmp++;
    if (pulses != TOTAL) begin
      n_bad++;
      $display("FAIL store_count got=%0d want=%0d", pulses, TOTAL);
    end
    n_cmp++;
    if (fw_cnt != 8 * NPIX) begin
      n_bad++;
      $display("FAIL first_write_count got=%0d want=%0d", fw_cnt, 8 * NPIX);
    end
    n_cmp++;
    if (excl_bad != 0) begin
      n_bad++;
      $display("FAIL strobe_exclusive_accum got=%0d overlaps want=0", excl_bad);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL in_ready_after_last got=%b want=0", in_ready);
    end
  endtask

  task automatic test_pool();
    int k = 0;
    int cyc = 0;
    int gap_bad = 0;
    bit started = 1'b0;
    bit ended = 1'b0;
    bit seen_gen = 1'b0;
    while (!seen_gen && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (rf_pool) begin
        if (ended) gap_bad++;
        started = 1'b1;
        n_cmp++;
        if (rf_addr !== base_of(k)) begin
          n_bad++;
          $display("FAIL pool_addr window %0d got=%0d want=%0d", k, rf_addr, base_of(k));
        end
        k++;
      end else if (started) begin
        ended = 1'b1;
      end
      if (rf_addr_gen) begin
        seen_gen = 1'b1;
        n_cmp++;
        if ({rf_pool, rf_addr} !== {1'b0, 10'd0}) begin
          n_bad++;
          $display("FAIL first_read got pool=%b addr=%0d want pool=0 addr=0", rf_pool, rf_addr);
        end
      end
    end
    n_cmp++;
    if (k != 196 || gap_bad != 0 || !seen_gen) begin
      n_bad++;
      $display("FAIL pool_run got windows=%0d gaps=%0d read_seen=%b want 196/0/1", k, gap_bad, seen_gen);
    end
  endtask

  task automatic test_readout(input bit stall_en);
    int exp_q[$];
    int gens = 0;
    int xfers = 0;
    int stall = 0;
    int cyc = 0;
    int want;
    bit fin = 1'b0;
    while (!fin && cyc < 1000) begin
      if (rf_addr_gen) begin
        n_cmp++;
        if (rf_addr !== base_of(gens)) begin
          n_bad++;
          $display("FAIL read_addr pixel %0d got=%0d want=%0d", gens, rf_addr, base_of(gens));
        end
        exp_q.push_back(gens);
        gens++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL readout_order got out_valid index=%0d want a preceding read", out_index);
          out_ready = 1'b1;
        end else if (stall_en && xfers == 10 && stall < 5) begin
          n_cmp++;
          if (out_index !== 8'(exp_q[0])) begin
            n_bad++;
            $display("FAIL stall_hold got=%0d want=%0d", out_index, exp_q[0]);
          end
          out_ready = 1'b0;
          stall++;
        end else begin
          want = exp_q.pop_front();
          n_cmp++;
          if (out_index !== 8'(want)) begin
            n_bad++;
            $display("FAIL out_index got=%0d want=%0d", out_index, want);
          end
          out_ready = 1'b1;
          xfers++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) fin = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    out_ready = 1'b0;
    n_cmp++;
    if (cyc != (stall_en ? 397 : 392)) begin
      n_bad++;
      $display("FAIL readout_cycles got=%0d want=%0d", cyc, stall_en ? 397 : 392);
    end
    n_cmp++;
    if (xfers != 196 || stall != (stall_en ? 5 : 0)) begin
      n_bad++;
      $display("FAIL readout_count got xfers=%0d stalls=%0d want 196/%0d", xfers, stall, stall_en ? 5 : 0);
    end
    n_cmp++;
    if ({done, busy, out_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL done_state got done=%b busy=%b valid=%b want 1/0/0", done, busy, out_valid);
    end
  endtask

  task automatic test_perf_held();
    logic [31:0] first;
    first = perf_cycles;
    repeat (3) @(posedge clk);
    #1;
`ifdef SEQ_PERF_CNT_EN
    n_cmp++;
    if (first !== 32'd13138) begin
      n_bad++;
      $display("FAIL perf_frame got=%0d want=13138", first);
    end
`else
    n_cmp++;
    if (first !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_tied got=%0d want=0", first);
    end
`endif
    n_cmp++;
    if (perf_cycles !== first || done !== 1'b1) begin
      n_bad++;
      $display("FAIL perf_held got=%0d done=%b want=%0d done=1", perf_cycles, done, first);
    end
  endtask

  task automatic test_abort_pool();
    int seen = 0;
    int cyc = 0;
    int late = 0;
    test_accum_stream(1'b0);
    while (seen < 50 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (rf_pool) seen++;
    end
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (seen != 50) begin
      n_bad++;
      $display("FAIL abort_window got=%0d want=50", seen);
    end
    n_cmp++;
    if ({busy, done, rf_pool, rf_store, rf_addr_gen, out_valid} !== 6'b0) begin
      n_bad++;
      $display("FAIL abort_idle got busy=%b done=%b pool=%b want all 0", busy, done, rf_pool);
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (rf_pool || busy) late++;
    end
    n_cmp++;
    if (late != 0) begin
      n_bad++;
      $display("FAIL abort_quiet got=%0d active cycles want=0", late);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_accum();
    test_accum_stream(1'b0);
    test_pool();
    test_readout(1'b1);
    test_perf_held();
    test_abort_pool();
    test_accum_stream(1'b1);
    test_pool();
    test_readout(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_result_sequencer.md
Name: conv_result_sequencer

Overview:
- FSM that sequences the eight-bank convolution result register file through three phases: accumulate, pool and readout.
  - Accumulate: streams MAC results into the banks.
  - Pool: walks the 2x2/stride-2 window bases.
  - Readout: presents the pooled 14x14x8 map to the next layer over a valid/ready handshake.
- Sits between the MAC array and the result register file; the top-level controller starts it and sees done.

Parameters:
- IMG_W, 28, feature-map width and height (square).
- OUT_CH, 8, output channels (banks).
- IN_CH, 4, input channels accumulated per output pixel.
- ADDR_W, 10, register-file address width.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame.
- abort  in  1  synchronous; returns the FSM to IDLE.
- in_valid  in  1  MAC result beat valid.
- in_ready  out  1  sequencer accepts a beat.
- in_value  in  8  signed MAC result.
- in_bias  in  8  signed bias of the current out channel.
- rf_store  out  1  register-file store strobe.
- rf_pool  out  1  register-file pool strobe.
- rf_addr_gen  out  1  register-file read strobe.
- rf_out_c  out  4  bank select.
- rf_addr  out  ADDR_W  bank address.
- rf_first_write  out  1  first-write flag (ic==0).
- rf_value  out  8  value to store.
- rf_bias  out  8  bias to store.
- out_valid  out  1  pooled pixel available.
- out_ready  in  1  consumer accepts the pixel.
- out_index  out  8  pooled pixel index 0..195.
- busy  out  1  FSM not in IDLE/DONE.
- done  out  1  level; frame complete.
- perf_cycles  out  32  busy-cycle count (optional feature).

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0; all counters 0.
  - Reset mid-operation aborts immediately; partial register-file contents are don't-care.
- States: IDLE, ACCUM, POOL, READ, WAIT_ACK, DONE.
- IDLE/DONE:
  - start moves to ACCUM next cycle, clears done and counters.
  - start in any other state is ignored.
- ACCUM:
  - in_ready=1.
  - Beat order: ic outer, then oc, then pix 0..IMG_W*IMG_W-1 (raster).
  - Each accepted beat (in_valid&in_ready) produces, registered with 1-cycle latency:
    - rf_store=1 for one cycle;
    - rf_out_c=oc, rf_addr=pix, rf_first_write=(ic==0);
    - rf_value=in_value, rf_bias=in_bias.
  - No beat accepted: rf_store=0.
  - Counters wrap pix→oc→ic.
  - Last beat (ic=IN_CH-1, oc=OUT_CH-1, pix=783): in_ready=0 from the next cycle, then go to POOL.
- POOL:
  - Drives rf_pool=1 one cycle per window (registered outputs) with rf_addr = 2*IMG_W*r + 2*c, for r,c in 0..IMG_W/2-1, c fastest.
  - First base 0; second base 2; row-1 base 56; last base 754.
  - 196 consecutive cycles, no gaps; rf_pool deasserts the cycle after base 754.
  - Then go to READ.
- READ:
  - One cycle of rf_addr_gen=1 with rf_addr = current base (same r,c walk).
  - Then WAIT_ACK.
- WAIT_ACK:
  - out_valid=1 from the cycle after rf_addr_gen; out_index=14*r+c.
  - Held stable until out_ready.
  - On out_valid&out_ready: advance (r,c).
    - Index 195 transfers: go to DONE.
    - Otherwise go to READ.
  - out_ready=1 continuously gives one pixel per 2 cycles.
- DONE: done=1, busy=0; holds until start.
- abort: any state returns to IDLE next cycle; all strobes 0 that cycle. abort has priority over start and handshakes.
- in_valid outside ACCUM is ignored (in_ready=0).
- Strobes rf_store/rf_pool/rf_addr_gen are mutually exclusive, never two high at once.
- Address arithmetic is unsigned ADDR_W; no overflow for IMG_W≤28.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - perf_cycles counts cycles with busy=1, saturating at 2^32-1.
  - Cleared on start and reset; held in DONE.
- Undefined: perf_cycles tied to 0; no counter logic.

Decomposition:
- Package conv_seq_pkg holds:
  - state encoding enum;
  - constants POOL_W=IMG_W/2, POOL_PIX=POOL_W*POOL_W, CH_PIX=IMG_W*IMG_W;
  - ADDR_W default.
- One sub-module, pool_walk_gen:
  - r/c counters with advance, clear and last outputs;
  - base-address and index outputs.
  - Instantiated once and shared by POOL and READ, since the phases never overlap.

Test Plan:
- Reset mid-ACCUM after 100 beats → next cycle state IDLE, all outputs 0, in_ready=0; start afterwards restarts at pix 0, ic 0.
- IN_CH=2, OUT_CH=8, in_valid always 1 → 12544 rf_store pulses:
  - rf_first_write=1 on the first 6272 pulses and 0 on the rest;
  - pulse 785 has rf_out_c=1, rf_addr=0.
- in_valid toggling 1/0 → rf_store follows with 1-cycle lag, never asserted on idle cycles; beat count still 12544.
- POOL phase → exactly 196 consecutive rf_pool cycles, rf_addr sequence 0, 2, …, 26, 56, …, 754; then rf_addr_gen begins.
- Readout with out_ready low 5 cycles at index 10 → out_valid and out_index=10 held stable; with out_ready=1 continuously, 196 transfers take 392 cycles, then done=1.
- abort asserted during POOL at window 50, together with start → IDLE, no further rf_pool; a later start gives a clean full frame; with SEQ_PERF_CNT_EN, perf_cycles restarts from 0.
